list_fold_sum: RTL and testbench

//   Downstream consumer for a list-stream producer (e.g. a list-literal generator). When start is asserted it

---
 rtl/list_fold_sum.sv | 169 ++++++++++++++++
 tb/tb_list_fold_sum.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/list_fold_sum.sv
// Terminal fold stage for a list stream: pulls elements over a 4-phase req/ack
// handshake and reports their saturating sum and count with a sticky done flag.
module list_fold_sum #(
  parameter int DATA_WIDTH     = 8,
  parameter int ACC_WIDTH      = 16,
  parameter int COUNT_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   start_i,
  output logic                   req_o,
  input  logic                   ack_i,
  input  logic                   eol_i,
  input  logic [DATA_WIDTH-1:0]  value_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [ACC_WIDTH-1:0]   sum_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   ovf_o,
  output logic                   timeout_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_RELEASE  = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [2:0]             state;
  logic                   start_s;
  logic                   start_q;
  logic                   ack_q;
  logic                   eol_q;
  logic [DATA_WIDTH-1:0]  value_q;
  logic [WD_W-1:0]        wd;

  logic                   start_rise;
  logic                   wd_expired;
  logic [ACC_WIDTH:0]     sum_ext;
  logic [COUNT_WIDTH:0]   count_ext;

  always_comb begin
    start_rise = start_s & ~start_q;
    wd_expired = (TIMEOUT_CYCLES != 0) && (wd == WD_W'(TIMEOUT_CYCLES - 1));
    sum_ext    = {1'b0, sum_o} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, value_q};
    count_ext  = {1'b0, count_o} + {{COUNT_WIDTH{1'b0}}, 1'b1};
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      start_s   <= 1'b0;
      start_q   <= 1'b0;
      ack_q     <= 1'b0;
      eol_q     <= 1'b0;
      value_q   <= '0;
      wd        <= '0;
      req_o     <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      sum_o     <= '0;
      count_o   <= '0;
      ovf_o     <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      start_s <= start_i;
      start_q <= start_s;
      ack_q   <= ack_i;
      eol_q   <= eol_i;
      // value is held by the producer while ack is high, so this copy stays aligned with ack_q
      value_q <= value_i;

      case (state)
        S_IDLE, S_DONE: begin
          if (start_rise) begin
            sum_o     <= '0;
            count_o   <= '0;
            done_o    <= 1'b0;
            ovf_o     <= 1'b0;
            timeout_o <= 1'b0;
            busy_o    <= 1'b1;
            state     <= S_REQ;
          end
        end

        S_REQ: begin
          wd <= '0;
          if (!start_s) begin
            state <= S_FINISH;
          end else begin
            req_o <= 1'b1;
            state <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          // abort wins over a simultaneous ack so no element is taken after start drops
          if (!start_s) begin
            req_o <= 1'b0;
            wd    <= '0;
            state <= S_FINISH;
          end else if (ack_q) begin
            req_o <= 1'b0;
            wd    <= '0;
            if (eol_q) begin
              state <= S_FINISH;
            end else begin
              if (sum_ext[ACC_WIDTH]) begin
                sum_o <= '1;
                ovf_o <= 1'b1;
              end else begin
                sum_o <= sum_ext[ACC_WIDTH-1:0];
              end
              if (count_ext[COUNT_WIDTH]) begin
                count_o <= '1;
                ovf_o   <= 1'b1;
              end else begin
                count_o <= count_ext[COUNT_WIDTH-1:0];
              end
              state <= S_RELEASE;
            end
          end else if (wd_expired) begin
            timeout_o <= 1'b1;
            req_o     <= 1'b0;
            wd        <= '0;
            state     <= S_FINISH;
          end else if (TIMEOUT_CYCLES != 0) begin
            wd <= wd + 1'b1;
          end
        end

        S_RELEASE: begin
          if (!start_s) begin
            wd    <= '0;
            state <= S_FINISH;
          end else if (!ack_q) begin
            state <= S_REQ;
          end
        end

        S_FINISH: begin
          if (!ack_q) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_DONE;
          end else if (wd_expired) begin
            timeout_o <= 1'b1;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            state     <= S_DONE;
          end else if (TIMEOUT_CYCLES != 0) begin
            wd <= wd + 1'b1;
          end
        end

        default: begin
          req_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_list_fold_sum.sv
// Scoreboard bench for list_fold_sum: a randomized producer serves lists, a
// monitor checks each completed fold against a plain-arithmetic reference.
module tb_list_fold_sum;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int CW = 4;
  localparam int TO = 16;
  localparam int SUM_MAX = (1 << AW) - 1;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int P_IDLE = 0, P_DELAY = 1, P_ACK = 2;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start_i  = 1'b0;
  logic          ack_i    = 1'b0;
  logic          eol_i    = 1'b0;
  logic [DW-1:0] value_i  = '0;
  logic          req_o, busy_o, done_o, ovf_o, timeout_o;
  logic [AW-1:0] sum_o;
  logic [CW-1:0] count_o;

  list_fold_sum #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start_i(start_i), .req_o(req_o),
    .ack_i(ack_i), .eol_i(eol_i), .value_i(value_i), .busy_o(busy_o),
    .done_o(done_o), .sum_o(sum_o), .count_o(count_o), .ovf_o(ovf_o),
    .timeout_o(timeout_o)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int sum;
    int count;
    int ovf;
    int to;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] stim_list[$];
  logic [DW-1:0] prod_q[$];
  bit            never_ack = 1'b0;
  int            req_rises = 0;
  int            n_checks  = 0;
  int            n_pass    = 0;
  int            last_cyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Reference: the fold result is just the clipped arithmetic sum and length of the list.
  function automatic exp_t model(input bit to_exp, input bit aborted);
    exp_t e;
    int   s;
    int   n;
    s = 0;
    n = stim_list.size();
    foreach (stim_list[i]) s += int'(stim_list[i]);
    if (to_exp || aborted) begin
      e.sum = 0; e.count = 0; e.ovf = 0; e.to = to_exp ? 1 : 0;
    end else begin
      e.sum   = (s > SUM_MAX) ? SUM_MAX : s;
      e.count = (n > CNT_MAX) ? CNT_MAX : n;
      e.ovf   = ((s > SUM_MAX) || (n > CNT_MAX)) ? 1 : 0;
      e.to    = 0;
    end
    return e;
  endfunction

  // Producer: 4-phase responder with a random 0-5 cycle ack delay
  initial begin : producer
    int pstate;
    int dly;
    pstate = P_IDLE;
    dly    = 0;
    forever begin
      @(negedge CLOCK_50);
      if (!reset_n) begin
        ack_i = 1'b0; eol_i = 1'b0; pstate = P_IDLE;
      end else begin
        case (pstate)
          P_IDLE: if (req_o) begin
            dly = $urandom_range(0, 5);
            pstate = P_DELAY;
          end
          P_DELAY: begin
            if (!req_o) pstate = P_IDLE;
            else if (never_ack) pstate = P_DELAY;
            else if (dly == 0) begin
              if (prod_q.size() != 0) begin
                value_i = prod_q.pop_front();
                eol_i   = 1'b0;
              end else begin
                value_i = DW'($urandom);
                eol_i   = 1'b1;
              end
              ack_i  = 1'b1;
              pstate = P_ACK;
            end else dly--;
          end
          default: if (!req_o) begin
            ack_i = 1'b0; eol_i = 1'b0; pstate = P_IDLE;
          end
        endcase
      end
    end
  end

  initial begin : monitor
    logic done_prev;
    logic req_prev;
    exp_t e;
    done_prev = 1'b0;
    req_prev  = 1'b0;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (req_o && !req_prev) begin
        req_rises++;
        check("req_rise_ack_low", {31'b0, ack_i}, 0);
      end
      if (done_o && !done_prev) begin
        check("done_expected", {31'b0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sum", sum_o, e.sum);
          check("count", count_o, e.count);
          check("ovf", {31'b0, ovf_o}, e.ovf);
          check("timeout", {31'b0, timeout_o}, e.to);
          check("busy_low_at_done", {31'b0, busy_o}, 0);
          check("req_low_at_done", {31'b0, req_o}, 0);
        end
      end
      done_prev = done_o;
      req_prev  = req_o;
    end
  end

  task automatic run_fold(input bit na, input int abort_after, input bit to_exp);
    int cyc;
    bit seen_low;
    exp_q.push_back(model(to_exp, abort_after > 0));
    prod_q    = stim_list;
    never_ack = na;
    @(negedge CLOCK_50);
    start_i  = 1'b1;
    cyc      = 0;
    seen_low = 1'b0;
    while (cyc < 2000) begin
      @(posedge CLOCK_50);
      #1;
      cyc++;
      if (abort_after > 0 && cyc == abort_after) start_i = 1'b0;
      if (!done_o) seen_low = 1'b1;
      else if (seen_low) break;
    end
    last_cyc = cyc;
    if (cyc >= 2000) check("fold_completes", 0, 1);
    @(negedge CLOCK_50);
    start_i   = 1'b0;
    never_ack = 1'b0;
    repeat (3) @(negedge CLOCK_50);
  endtask

  initial begin : stimulus
    int r0;
    int len;
    int vmax;
    int waited;

    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", {req_o, busy_o, done_o, ovf_o, timeout_o, sum_o, count_o}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    stim_list = '{8'd2, 8'd12, 8'd30};
    run_fold(1'b0, 0, 1'b0);

    stim_list = {};
    r0 = req_rises;
    run_fold(1'b0, 0, 1'b0);
    check("empty_one_req", req_rises - r0, 1);

    stim_list = '{8'd200, 8'd100};
    run_fold(1'b0, 0, 1'b0);

    stim_list = {};
    run_fold(1'b1, 0, 1'b1);
    check("timeout_latency_18_22", {31'b0, (last_cyc >= 18) && (last_cyc <= 22)}, 1);

    stim_list = '{8'd9, 8'd9};
    run_fold(1'b1, 5, 1'b0);

    stim_list = {};
    for (int i = 0; i < 20; i++) stim_list.push_back(DW'($urandom_range(0, 12)));
    run_fold(1'b0, 0, 1'b0);

    // asynchronous reset while the DUT is waiting for an ack
    stim_list = '{8'd5, 8'd6, 8'd7};
    prod_q    = stim_list;
    never_ack = 1'b1;
    @(negedge CLOCK_50);
    start_i = 1'b1;
    waited  = 0;
    while (!req_o && waited < 50) begin
      @(posedge CLOCK_50);
      #1;
      waited++;
    end
    check("req_before_reset", {31'b0, req_o}, 1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", {req_o, busy_o, done_o, ovf_o, timeout_o, sum_o, count_o}, 0);
    start_i   = 1'b0;
    never_ack = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    run_fold(1'b0, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      len  = $urandom_range(0, 20);
      vmax = ($urandom_range(0, 1) != 0) ? 255 : 12;
      stim_list = {};
      for (int i = 0; i < len; i++) stim_list.push_back(DW'($urandom_range(0, vmax)));
      run_fold(1'b0, 0, 1'b0);
    end

    repeat (5) @(negedge CLOCK_50);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
